// File: rtl/time_set_ctrl.sv
// Push-button time entry: debounces mode/inc/dec and edits a snapshot of the
// running HH:MM:SS time, emitting the result with a one-cycle load strobe.
module time_set_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int DB_W            = 18
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mode_n,
    input  logic        inc_n,
    input  logic        dec_n,
    input  logic [23:0] time_in,
    output logic        set_active,
    output logic [1:0]  field_sel,
    output logic [23:0] time_out,
    output logic        load
);

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, SET_H, SET_M, SET_S, COMMIT} state_t;

    logic [2:0] btn_raw_n;
    logic [2:0] btn_evt;

    assign btn_raw_n = {dec_n, inc_n, mode_n};

    // Bit 0 = mode, 1 = inc, 2 = dec. Buttons idle high.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_btn
            logic            sync1_reg;
            logic            sync2_reg;
            logic            db_reg;
            logic            db_d_reg;
            logic            press_reg;
            logic [DB_W-1:0] cnt_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    sync1_reg <= 1'b1;
                    sync2_reg <= 1'b1;
                    db_reg    <= 1'b1;
                    db_d_reg  <= 1'b1;
                    press_reg <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    sync1_reg <= btn_raw_n[gi];
                    sync2_reg <= sync1_reg;
                    if (sync2_reg == db_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == DB_LAST) begin
                        db_reg  <= sync2_reg;
                        cnt_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                    db_d_reg  <= db_reg;
                    press_reg <= db_d_reg & ~db_reg;
                end
            end

            assign btn_evt[gi] = press_reg;
        end
    endgenerate

    // Mode beats inc/dec; inc together with dec cancels out.
    logic mode_evt, inc_evt, dec_evt;
    assign mode_evt = btn_evt[0];
    assign inc_evt  = btn_evt[1] & ~btn_evt[2] & ~mode_evt;
    assign dec_evt  = btn_evt[2] & ~btn_evt[1] & ~mode_evt;

    function automatic logic pair_valid(input logic [7:0] p, input logic [7:0] mx);
        return (p[3:0] <= 4'd9) &&
               ((p[7:4] < mx[7:4]) || ((p[7:4] == mx[7:4]) && (p[3:0] <= mx[3:0])));
    endfunction

    // Out-of-range pairs snap to 00 on inc and to the maximum on dec.
    function automatic logic [7:0] bcd_inc(input logic [7:0] p, input logic [7:0] mx);
        if (!pair_valid(p, mx) || p == mx)
            return 8'h00;
        else if (p[3:0] == 4'd9)
            return {p[7:4] + 4'd1, 4'h0};
        else
            return {p[7:4], p[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] p, input logic [7:0] mx);
        if (!pair_valid(p, mx) || p == 8'h00)
            return mx;
        else if (p[3:0] == 4'd0)
            return {p[7:4] - 4'd1, 4'h9};
        else
            return {p[7:4], p[3:0] - 4'd1};
    endfunction

    state_t      state_reg;
    logic [23:0] time_reg;
    logic        load_reg;
    logic        active_reg;
    logic [1:0]  field_reg;

    logic [7:0] sel_pair;
    logic [7:0] sel_max;
    logic [7:0] edited_pair;

    always_comb begin
        sel_pair = time_reg[23:16];
        sel_max  = 8'h23;
        case (state_reg)
            SET_M: begin
                sel_pair = time_reg[15:8];
                sel_max  = 8'h59;
            end
            SET_S: begin
                sel_pair = time_reg[7:0];
                sel_max  = 8'h59;
            end
            default: begin
                sel_pair = time_reg[23:16];
                sel_max  = 8'h23;
            end
        endcase
        edited_pair = inc_evt ? bcd_inc(sel_pair, sel_max) : bcd_dec(sel_pair, sel_max);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            time_reg   <= '0;
            load_reg   <= 1'b0;
            active_reg <= 1'b0;
            field_reg  <= 2'd0;
        end else begin
            load_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (mode_evt) begin
                        time_reg   <= time_in;
                        state_reg  <= SET_H;
                        field_reg  <= 2'd1;
                        active_reg <= 1'b1;
                    end
                end
                SET_H, SET_M, SET_S: begin
                    if (mode_evt) begin
                        case (state_reg)
                            SET_H: begin
                                state_reg <= SET_M;
                                field_reg <= 2'd2;
                            end
                            SET_M: begin
                                state_reg <= SET_S;
                                field_reg <= 2'd3;
                            end
                            default: begin
                                state_reg <= COMMIT;
                                field_reg <= 2'd0;
                                load_reg  <= 1'b1;
                            end
                        endcase
                    end else if (inc_evt || dec_evt) begin
                        case (state_reg)
                            SET_H:   time_reg[23:16] <= edited_pair;
                            SET_M:   time_reg[15:8]  <= edited_pair;
                            default: time_reg[7:0]   <= edited_pair;
                        endcase
                    end
                end
                COMMIT: begin
                    state_reg  <= IDLE;
                    active_reg <= 1'b0;
                    field_reg  <= 2'd0;
                end
                default: begin
                    state_reg  <= IDLE;
                    active_reg <= 1'b0;
                    field_reg  <= 2'd0;
                end
            endcase
        end
    end

    assign set_active = active_reg;
    assign field_sel  = field_reg;
    assign time_out   = time_reg;
    assign load       = load_reg;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: directed vector table, latency/reset sequences,
// then random button traffic against an arithmetic reference model.
module tb_time_set_ctrl;

    logic        clk;
    logic        reset;
    logic        mode_n, inc_n, dec_n;
    logic [23:0] time_in;
    logic        set_active;
    logic [1:0]  field_sel;
    logic [23:0] time_out;
    logic        load;

    time_set_ctrl #(.DEBOUNCE_CYCLES(4), .DB_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .mode_n    (mode_n),
        .inc_n     (inc_n),
        .dec_n     (dec_n),
        .time_in   (time_in),
        .set_active(set_active),
        .field_sel (field_sel),
        .time_out  (time_out),
        .load      (load)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          load_cnt = 0;
    logic [23:0] load_val = '0;

    // Count every cycle the strobe is high and remember what it carried.
    always @(posedge clk) begin
        #1;
        if (load === 1'b1) begin
            load_cnt = load_cnt + 1;
            load_val = time_out;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [2:0] mask, input int hold);
        mode_n = ~mask[0];
        inc_n  = ~mask[1];
        dec_n  = ~mask[2];
        tick(hold);
        mode_n = 1'b1;
        inc_n  = 1'b1;
        dec_n  = 1'b1;
        tick(12);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(2);
    endtask

    typedef struct {
        logic [2:0]  btn;
        int          reps;
        int          hold;
        logic [23:0] tin;
        bit          rst;
        logic [1:0]  exp_fs;
        logic [23:0] exp_tout;
        int          exp_loads;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [2:0] b, input int r, input int h, input logic [23:0] t,
                       input bit rs, input logic [1:0] fs, input logic [23:0] to, input int ld);
        vec_t v;
        v.btn = b; v.reps = r; v.hold = h; v.tin = t; v.rst = rs;
        v.exp_fs = fs; v.exp_tout = to; v.exp_loads = ld;
        tbl.push_back(v);
    endtask

    // Reference edit: plain decimal arithmetic with modulo wrap.
    function automatic logic [7:0] model_step(input logic [7:0] p, input int mx, input bit up);
        int t, u, v;
        bit ok;
        t  = int'(p[7:4]);
        u  = int'(p[3:0]);
        ok = (t <= 9) && (u <= 9) && (t * 10 + u <= mx);
        if (!ok)
            v = up ? 0 : mx;
        else
            v = up ? (t * 10 + u + 1) % (mx + 1) : (t * 10 + u + mx) % (mx + 1);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    logic [7:0]  mf[3];
    int          msel;
    int          mloads;
    logic [23:0] mlast;

    initial begin
        reset   = 1'b1;
        mode_n  = 1'b1;
        inc_n   = 1'b1;
        dec_n   = 1'b1;
        time_in = 24'h000000;
        tick(3);
        reset = 1'b0;
        tick(1);

        // Reset state and a quiet idle period.
        chk("reset_tout", 32'(time_out), 32'h0);
        chk("reset_fs", 32'(field_sel), 32'h0);
        chk("reset_load", 32'(load), 32'h0);
        chk("reset_active", 32'(set_active), 32'h0);
        tick(50);
        chk("idle_loads", 32'(load_cnt), 32'h0);
        chk("idle_fs", 32'(field_sel), 32'h0);
        $display("reset/idle: fs=%0d tout=%h loads=%0d", field_sel, time_out, load_cnt);

        // Raw press to state change: 7 edges for the event, one more for the FSM.
        time_in = 24'h081522;
        mode_n  = 1'b0;
        tick(7);
        chk("lat_before", 32'(field_sel), 32'h0);
        tick(1);
        chk("lat_fs", 32'(field_sel), 32'h1);
        chk("lat_tout", 32'(time_out), 32'h081522);
        $display("latency: fs=%0d tout=%h", field_sel, time_out);
        mode_n = 1'b1;
        tick(12);
        do_reset();
        chk("lat_reset_tout", 32'(time_out), 32'h0);

        add(3'b001, 1, 10, 24'h123456, 0, 2'd1, 24'h123456, 0);
        add(3'b010, 12, 10, 24'h123456, 0, 2'd1, 24'h003456, 0);
        add(3'b001, 1, 10, 24'h123456, 0, 2'd2, 24'h003456, 0);
        add(3'b100, 35, 10, 24'h123456, 0, 2'd2, 24'h005956, 0);
        add(3'b001, 1, 10, 24'h123456, 0, 2'd3, 24'h005956, 0);
        add(3'b001, 1, 10, 24'h123456, 0, 2'd0, 24'h005956, 1);
        add(3'b001, 1, 10, 24'h235956, 0, 2'd1, 24'h235956, 1);
        add(3'b010, 1, 10, 24'h235956, 0, 2'd1, 24'h005956, 1);
        add(3'b100, 1, 10, 24'h235956, 0, 2'd1, 24'h235956, 1);
        add(3'b100, 4, 10, 24'h235956, 0, 2'd1, 24'h195956, 1);
        add(3'b001, 2, 10, 24'h235956, 0, 2'd3, 24'h195956, 1);
        add(3'b010, 1, 3, 24'h235956, 0, 2'd3, 24'h195956, 1);
        add(3'b010, 1, 40, 24'h235956, 0, 2'd3, 24'h195957, 1);
        add(3'b110, 1, 10, 24'h235956, 0, 2'd3, 24'h195957, 1);
        add(3'b001, 1, 10, 24'h235956, 0, 2'd0, 24'h195957, 2);
        add(3'b001, 1, 10, 24'h123456, 0, 2'd1, 24'h123456, 2);
        add(3'b011, 1, 10, 24'h123456, 0, 2'd2, 24'h123456, 2);
        add(3'b100, 27, 10, 24'h123456, 0, 2'd2, 24'h120756, 2);
        add(3'b000, 0, 0, 24'h123456, 1, 2'd0, 24'h000000, 2);
        add(3'b001, 1, 10, 24'h256199, 0, 2'd1, 24'h256199, 2);
        add(3'b010, 1, 10, 24'h256199, 0, 2'd1, 24'h006199, 2);
        add(3'b001, 1, 10, 24'h256199, 0, 2'd2, 24'h006199, 2);
        add(3'b100, 1, 10, 24'h256199, 0, 2'd2, 24'h005999, 2);
        add(3'b001, 1, 10, 24'h256199, 0, 2'd3, 24'h005999, 2);
        add(3'b010, 1, 10, 24'h256199, 0, 2'd3, 24'h005900, 2);
        add(3'b001, 1, 10, 24'h256199, 0, 2'd0, 24'h005900, 3);
        add(3'b010, 1, 10, 24'h111111, 0, 2'd0, 24'h005900, 3);

        for (int i = 0; i < tbl.size(); i++) begin
            int loads_before;
            loads_before = load_cnt;
            time_in = tbl[i].tin;
            if (tbl[i].rst)
                do_reset();
            else
                for (int r = 0; r < tbl[i].reps; r++)
                    press(tbl[i].btn, tbl[i].hold);
            chk($sformatf("vec%0d_fs", i), 32'(field_sel), 32'(tbl[i].exp_fs));
            chk($sformatf("vec%0d_tout", i), 32'(time_out), 32'(tbl[i].exp_tout));
            chk($sformatf("vec%0d_active", i), 32'(set_active), 32'(tbl[i].exp_fs != 2'd0));
            chk($sformatf("vec%0d_loads", i), 32'(load_cnt), 32'(tbl[i].exp_loads));
            if (load_cnt != loads_before)
                chk($sformatf("vec%0d_loadval", i), 32'(load_val), 32'(tbl[i].exp_tout));
            $display("vec %0d btn=%b reps=%0d fs=%0d tout=%h loads=%0d",
                     i, tbl[i].btn, tbl[i].reps, field_sel, time_out, load_cnt);
        end

        // Random traffic; model starts from the state the table left behind.
        mf[0] = 8'h00; mf[1] = 8'h59; mf[2] = 8'h00;
        msel = 0; mloads = 3; mlast = 24'h005900;
        for (int n = 0; n < 150; n++) begin
            logic [2:0]  mask;
            logic [23:0] tin;
            int          sel;
            int          loads_before;
            sel = $urandom_range(0, 9);
            if (sel < 3)      mask = 3'b001;
            else if (sel < 6) mask = 3'b010;
            else if (sel < 9) mask = 3'b100;
            else              mask = 3'($urandom_range(3, 7));
            for (int d = 0; d < 6; d++)
                tin[d*4 +: 4] = 4'($urandom_range(0, 9));
            time_in = tin;
            loads_before = load_cnt;
            press(mask, 10);

            if (mask[0]) begin
                if (msel == 0) begin
                    mf[0] = tin[23:16]; mf[1] = tin[15:8]; mf[2] = tin[7:0];
                    msel = 1;
                end else if (msel == 3) begin
                    mloads++;
                    mlast = {mf[0], mf[1], mf[2]};
                    msel = 0;
                end else begin
                    msel++;
                end
            end else if ((mask[1] != mask[2]) && msel != 0) begin
                mf[msel-1] = model_step(mf[msel-1], (msel == 1) ? 23 : 59, mask[1]);
            end

            chk("rnd_fs", 32'(field_sel), 32'(msel));
            chk("rnd_tout", 32'(time_out), 32'({mf[0], mf[1], mf[2]}));
            chk("rnd_active", 32'(set_active), 32'(msel != 0));
            chk("rnd_loads", 32'(load_cnt), 32'(mloads));
            if (load_cnt != loads_before)
                chk("rnd_loadval", 32'(load_val), 32'(mlast));
            $display("rnd %0d btn=%b tin=%h fs=%0d tout=%h loads=%0d",
                     n, mask, tin, field_sel, time_out, load_cnt);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
